pipe_skid_reg: RTL

- Parametrised pipeline stage register that adds a valid/ready handshake and a one-entry skid buffer, so stages can stall without a combinational ready path between them.
- Successor to the plain enable/clear stage register.
- Sits between pipeline stages (e.g. IF/ID, ID/EX) and between the datapath and memory or multi-cycle units.
- Supports full throughput, back-pressure and synchronous flush.

---
 rtl/pipe_skid_reg_pkg.sv | 24 ++
 rtl/pipe_data_reg.sv | 34 +++
 rtl/pipe_skid_reg.sv | 125 ++++++++++++
 3 files changed

// File: rtl/pipe_skid_reg_pkg.sv
// pipe_skid_reg_pkg
//   Shared definitions for the skid-buffered pipeline stage register:
//   state encoding (EMPTY / ONE / FULL) and the state-to-count decode.
package pipe_skid_reg_pkg;

    localparam int PSR_COUNT_W = 2;

    typedef enum logic [1:0] {
        PSR_EMPTY = 2'd0,
        PSR_ONE   = 2'd1,
        PSR_FULL  = 2'd2
    } psr_state_t;

    // Number of entries held in a given state. Illegal encodings read as 0;
    // the controller forces them back to EMPTY on the next edge.
    function automatic logic [PSR_COUNT_W-1:0] psr_count(input psr_state_t s);
        case (s)
            PSR_ONE:  psr_count = 2'd1;
            PSR_FULL: psr_count = 2'd2;
            default:  psr_count = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// pipe_data_reg
//   WIDTH-wide payload register with load enable and synchronous clear.
//   Clear has priority over load.
// Ports:
//   clk    input          clock, rising edge
//   i_clr  input          synchronous clear to zero
//   i_en   input          load i_d
//   i_d    input  [W-1:0] data to load
//   o_q    output [W-1:0] registered data
module pipe_data_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg
//   Pipeline stage register with valid/ready handshake and a one-entry skid
//   buffer. All outputs decode registered state only, so out_ready never
//   reaches in_ready combinationally. Full throughput, strict FIFO order.
// Ports:
//   clk        input          clock, rising edge
//   rst        input          synchronous active-high reset
//   flush      input          synchronous discard of all held entries
//   in_valid   input          upstream presents in_data
//   in_ready   output         stage can accept this cycle
//   in_data    input  [W-1:0] upstream payload
//   out_valid  output         out_data is valid
//   out_ready  input          downstream accepts this cycle
//   out_data   output [W-1:0] payload of the oldest held entry
//   count      output [1:0]   entries held (0..2)
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int CLEAR_DATA = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [PSR_COUNT_W-1:0] count
);

    localparam logic P_CLR = (CLEAR_DATA != 0);

    psr_state_t       r_state;
    psr_state_t       w_state_nxt;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_main_en;
    logic             w_main_from_skid;
    logic             w_skid_en;
    logic             w_main_clr;
    logic             w_skid_clr;
    logic [WIDTH-1:0] w_main_d;
    logic [WIDTH-1:0] w_main_q;
    logic [WIDTH-1:0] w_skid_q;

    // Only EMPTY and ONE accept; an illegal encoding refuses input so that
    // nothing is accepted and then lost during recovery to EMPTY.
    assign in_ready   = ((r_state == PSR_EMPTY) || (r_state == PSR_ONE)) && !rst;
    assign out_valid  = (r_state == PSR_ONE) || (r_state == PSR_FULL);
    assign count      = psr_count(r_state);
    assign out_data   = w_main_q;

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_main_en        = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_en        = 1'b0;
        case (r_state)
            PSR_EMPTY: begin
                if (w_in_fire) begin
                    w_main_en   = 1'b1;
                    w_state_nxt = PSR_ONE;
                end
            end
            PSR_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_main_en   = 1'b1;
                end else if (w_in_fire) begin
                    w_skid_en   = 1'b1;
                    w_state_nxt = PSR_FULL;
                end else if (w_out_fire) begin
                    w_state_nxt = PSR_EMPTY;
                end
            end
            PSR_FULL: begin
                if (w_out_fire) begin
                    w_main_en        = 1'b1;
                    w_main_from_skid = 1'b1;
                    w_state_nxt      = PSR_ONE;
                end
            end
            default: begin
                w_state_nxt = PSR_EMPTY;
            end
        endcase
        // rst and flush override normal operation.
        if (rst || flush) begin
            w_state_nxt = PSR_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        r_state <= w_state_nxt;
    end

    // Reset always zeroes the output register so out_data reads 0 after
    // reset; flush and the skid register only clear when CLEAR_DATA is set.
    // With CLEAR_DATA=0 a flush must still not load data, hence the gating.
    assign w_main_clr = rst || (flush && P_CLR);
    assign w_skid_clr = (rst || flush) && P_CLR;
    assign w_main_d   = w_main_from_skid ? w_skid_q : in_data;

    pipe_data_reg #(.WIDTH(WIDTH)) u_main (
        .clk   (clk),
        .i_clr (w_main_clr),
        .i_en  (w_main_en && !flush && !rst),
        .i_d   (w_main_d),
        .o_q   (w_main_q)
    );

    pipe_data_reg #(.WIDTH(WIDTH)) u_skid (
        .clk   (clk),
        .i_clr (w_skid_clr),
        .i_en  (w_skid_en && !flush && !rst),
        .i_d   (in_data),
        .o_q   (w_skid_q)
    );

endmodule
